// File: rtl/viterbi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : viterbi_pkg
// Purpose  : Shared state encoding and default traceback depth for the
//            rate-1/2 Viterbi frame sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package viterbi_pkg;

  localparam int unsigned TB_LEN_DEF = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT    = 3'd1,
    RUN     = 3'd2,
    DRAIN   = 3'd3,
    WAIT_TB = 3'd4
  } vit_state_t;

endpackage
`default_nettype wire

// File: rtl/viterbi_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : viterbi_ctrl
// Purpose  : Frame sequencer feeding BMU/ACS, ping-pong survivor writes and
//            per-bank traceback launch with partial-bank drain on flush.
// Revision : 1.0 - initial release
// ============================================================================
module viterbi_ctrl
  import viterbi_pkg::*;
#(
  parameter  int unsigned TB_LEN = TB_LEN_DEF,
  localparam int unsigned ADDR_W = $clog2(TB_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        rx_pair,
  input  logic              flush,
  output logic [1:0]        bmc_rx_pair,
  output logic              acs_init,
  output logic              acs_en,
  output logic              wr_en,
  output logic              wr_bank,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              tb_start,
  output logic              tb_bank,
  output logic [ADDR_W:0]   tb_len,
  input  logic              tb_done,
  output logic              frame_done,
  output logic              busy
);

  vit_state_t        state_q, state_d;
  logic [ADDR_W-1:0] ptr_addr_q, ptr_addr_d;
  logic              ptr_bank_q, ptr_bank_d;
  logic              pending_q, pending_d;
  logic [1:0]        pair_q, pair_d;
  logic              acs_en_q, acs_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              wr_bank_q, wr_bank_d;
  logic              tb_start_q, tb_start_d;
  logic              tb_bank_q, tb_bank_d;
  logic [ADDR_W:0]   tb_len_q, tb_len_d;
  logic              frame_done_q, frame_done_d;
  logic              last_slot;
  logic              accept;
  logic              frame_end;

  // ptr_* is the next slot to write; wr_* shows the slot written this cycle.
  assign last_slot = (ptr_addr_q == ADDR_W'(TB_LEN - 1));
  assign in_ready  = (state_q == RUN) && !(last_slot && pending_q);
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d      = state_q;
    ptr_addr_d   = ptr_addr_q;
    ptr_bank_d   = ptr_bank_q;
    pending_d    = pending_q;
    pair_d       = pair_q;
    acs_en_d     = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_bank_d    = wr_bank_q;
    tb_start_d   = 1'b0;
    tb_bank_d    = tb_bank_q;
    tb_len_d     = tb_len_q;
    frame_done_d = 1'b0;
    frame_end    = 1'b0;

    if (tb_done && pending_q) begin
      pending_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start) state_d = INIT;
      end
      INIT: begin
        state_d = RUN;
      end
      RUN: begin
        if (flush) state_d = DRAIN;
      end
      DRAIN: begin
        if (!pending_q) begin
          if (ptr_addr_q != '0) begin
            tb_start_d = 1'b1;
            tb_bank_d  = ptr_bank_q;
            tb_len_d   = {1'b0, ptr_addr_q};
            pending_d  = 1'b1;
            state_d    = WAIT_TB;
          end else begin
            frame_end = 1'b1;
          end
        end else if (ptr_addr_q == '0) begin
          // Only a full bank is outstanding; its done may land right here.
          if (tb_done) frame_end = 1'b1;
          else         state_d   = WAIT_TB;
        end
      end
      WAIT_TB: begin
        if (tb_done && pending_q) frame_end = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (frame_end) begin
      state_d      = IDLE;
      frame_done_d = 1'b1;
      ptr_addr_d   = '0;
      ptr_bank_d   = 1'b0;
      wr_addr_d    = '0;
      wr_bank_d    = 1'b0;
    end

    if (accept) begin
      acs_en_d   = 1'b1;
      pair_d     = rx_pair;
      wr_addr_d  = ptr_addr_q;
      wr_bank_d  = ptr_bank_q;
      ptr_addr_d = ptr_addr_q + ADDR_W'(1);
      if (last_slot) begin
        ptr_bank_d = ~ptr_bank_q;
        tb_start_d = 1'b1;
        tb_bank_d  = ptr_bank_q;
        tb_len_d   = (ADDR_W+1)'(TB_LEN);
        pending_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      ptr_addr_q   <= '0;
      ptr_bank_q   <= 1'b0;
      pending_q    <= 1'b0;
      pair_q       <= '0;
      acs_en_q     <= 1'b0;
      wr_addr_q    <= '0;
      wr_bank_q    <= 1'b0;
      tb_start_q   <= 1'b0;
      tb_bank_q    <= 1'b0;
      tb_len_q     <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_addr_q   <= ptr_addr_d;
      ptr_bank_q   <= ptr_bank_d;
      pending_q    <= pending_d;
      pair_q       <= pair_d;
      acs_en_q     <= acs_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_bank_q    <= wr_bank_d;
      tb_start_q   <= tb_start_d;
      tb_bank_q    <= tb_bank_d;
      tb_len_q     <= tb_len_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bmc_rx_pair = pair_q;
  assign acs_init    = (state_q == INIT);
  assign acs_en      = acs_en_q;
  assign wr_en       = acs_en_q;
  assign wr_bank     = wr_bank_q;
  assign wr_addr     = wr_addr_q;
  assign tb_start    = tb_start_q;
  assign tb_bank     = tb_bank_q;
  assign tb_len      = tb_len_q;
  assign frame_done  = frame_done_q;
  assign busy        = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_viterbi_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_viterbi_ctrl
// Purpose  : Self-checking bench for viterbi_ctrl with TB_LEN=4, random pairs
//            and a symbol-count reference model of the frame sequencing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_viterbi_ctrl;

  localparam int unsigned TB_LEN = 4;
  localparam int unsigned ADDR_W = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        rx_pair;
  logic              flush;
  logic [1:0]        bmc_rx_pair;
  logic              acs_init;
  logic              acs_en;
  logic              wr_en;
  logic              wr_bank;
  logic [ADDR_W-1:0] wr_addr;
  logic              tb_start;
  logic              tb_bank;
  logic [ADDR_W:0]   tb_len;
  logic              tb_done;
  logic              frame_done;
  logic              busy;

  always #5 clk = ~clk;

  viterbi_ctrl #(.TB_LEN(TB_LEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .rx_pair    (rx_pair),
    .flush      (flush),
    .bmc_rx_pair(bmc_rx_pair),
    .acs_init   (acs_init),
    .acs_en     (acs_en),
    .wr_en      (wr_en),
    .wr_bank    (wr_bank),
    .wr_addr    (wr_addr),
    .tb_start   (tb_start),
    .tb_bank    (tb_bank),
    .tb_len     (tb_len),
    .tb_done    (tb_done),
    .frame_done (frame_done),
    .busy       (busy)
  );

  int errs   = 0;
  int checks = 0;

  // Reference model: phase 0 idle, 1 init, 2 run, 3 drain, 4 awaiting last done
  int         ph;
  int         m_acc;
  logic       m_out;
  int         done_cd;
  int         tb_delay;
  logic       auto_done;
  logic       force_done;
  logic       exp_wr;
  logic       exp_tbs;
  logic       exp_fd;
  logic [1:0] exp_pair;
  int         exp_addr;
  int         exp_bank;
  int         exp_tbbank;
  int         exp_tblen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic timeout_fail(input string tag);
    checks++;
    errs++;
    $error("FAIL %s: observed=timeout expected=completion", tag);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; flush = 1'b0; tb_done = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk("reset_outputs", 32'({in_ready, bmc_rx_pair, acs_init, acs_en, wr_en, wr_bank,
                                wr_addr, tb_start, tb_bank, tb_len, frame_done, busy}), 32'd0);
    end
    rst = 1'b1;
    ph = 0; m_acc = 0; m_out = 1'b0; done_cd = 0; force_done = 1'b0; exp_pair = 2'b00;
  endtask

  task automatic end_frame();
    exp_fd = 1'b1;
    ph     = 0;
    m_acc  = 0;
  endtask

  task automatic tick(input logic v, input logic [1:0] p, input logic s, input logic f);
    logic d;
    logic rdy;
    logic acc;
    logic out_old;
    int   rem;
    d = force_done;
    if (done_cd > 0) begin
      done_cd--;
      if (done_cd == 0) d = 1'b1;
    end
    rdy = (ph == 2) && !(((m_acc % TB_LEN) == TB_LEN - 1) && m_out);
    acc = v && rdy;
    in_valid = v; rx_pair = p; start = s; flush = f; tb_done = d;
    chk("in_ready", 32'(in_ready), 32'(rdy));
    @(posedge clk); #1;

    exp_wr = acc; exp_tbs = 1'b0; exp_fd = 1'b0;
    out_old = m_out;
    if (d && out_old) m_out = 1'b0;
    if (acc) begin
      exp_pair = p;
      exp_addr = m_acc % TB_LEN;
      exp_bank = (m_acc / TB_LEN) % 2;
      if (exp_addr == TB_LEN - 1) begin
        exp_tbs = 1'b1; exp_tbbank = exp_bank; exp_tblen = TB_LEN; m_out = 1'b1;
      end
      m_acc++;
    end
    rem = m_acc % TB_LEN;
    case (ph)
      0: if (s) ph = 1;
      1: ph = 2;
      2: if (f) ph = 3;
      3: begin
        if (!out_old) begin
          if (rem != 0) begin
            exp_tbs = 1'b1; exp_tbbank = (m_acc / TB_LEN) % 2; exp_tblen = rem;
            m_out = 1'b1; ph = 4;
          end else begin
            end_frame();
          end
        end else if (rem == 0) begin
          if (d) end_frame();
          else   ph = 4;
        end
      end
      default: if (d && out_old) end_frame();
    endcase
    if (exp_tbs && auto_done) done_cd = tb_delay + 1;

    chk("acs_en", 32'(acs_en), 32'(exp_wr));
    chk("wr_en", 32'(wr_en), 32'(exp_wr));
    chk("bmc_rx_pair", 32'(bmc_rx_pair), 32'(exp_pair));
    if (exp_wr) begin
      chk("wr_addr", 32'(wr_addr), exp_addr);
      chk("wr_bank", 32'(wr_bank), exp_bank);
    end
    chk("tb_start", 32'(tb_start), 32'(exp_tbs));
    if (exp_tbs) begin
      chk("tb_bank", 32'(tb_bank), exp_tbbank);
      chk("tb_len", 32'(tb_len), exp_tblen);
    end
    chk("frame_done", 32'(frame_done), 32'(exp_fd));
    if (exp_fd) chk("ptr_cleared", 32'({wr_bank, wr_addr}), 32'd0);
    chk("busy", 32'(busy), 32'(ph != 0));
    chk("acs_init", 32'(acs_init), 32'(ph == 1));
  endtask

  task automatic start_frame();
    tick(1'b0, 2'b00, 1'b1, 1'b0);
    tick(1'b0, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic send_n(input int n, input logic sparse);
    int guard = 0;
    while (m_acc < n && guard < 400) begin
      guard++;
      tick(sparse ? logic'($urandom_range(0, 3) != 0) : 1'b1, 2'($urandom), 1'b0, 1'b0);
    end
    if (m_acc < n) timeout_fail("send");
  endtask

  task automatic drain_wait();
    int guard = 0;
    while (ph != 0 && guard < 200) begin
      guard++;
      tick(1'b0, 2'($urandom), 1'b0, 1'b0);
    end
    if (ph != 0) timeout_fail("drain");
  endtask

  task automatic finish_frame();
    tick(1'b0, 2'($urandom), 1'b0, 1'b1);
    drain_wait();
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; rx_pair = 2'b00; flush = 1'b0; tb_done = 1'b0;
    force_done = 1'b0; auto_done = 1'b1; tb_delay = 3; done_cd = 0;
    ph = 0; m_acc = 0; m_out = 1'b0; exp_pair = 2'b00;
    do_reset(2);

    // Back-to-back stream across both banks
    start_frame();
    send_n(8, 1'b0);
    finish_frame();

    // Single-symbol latency, then hold
    start_frame();
    tick(1'b1, 2'b10, 1'b0, 1'b0);
    chk("latency_pair", 32'(bmc_rx_pair), 32'h2);
    tick(1'b0, 2'b01, 1'b0, 1'b0);
    chk("latency_strobe_off", 32'(acs_en), 32'd0);
    finish_frame();

    // Withheld traceback on bank 0 stalls the last write of bank 1
    start_frame();
    auto_done = 1'b0;
    send_n(7, 1'b0);
    repeat (5) tick(1'b1, 2'($urandom), 1'b0, 1'b0);
    chk("stall_ready", 32'(in_ready), 32'd0);
    force_done = 1'b1;
    tick(1'b1, 2'($urandom), 1'b0, 1'b0);
    force_done = 1'b0;
    auto_done = 1'b1;
    chk("stall_release", 32'(in_ready), 32'd1);
    send_n(8, 1'b0);
    finish_frame();

    // Partial bank drained on flush
    start_frame();
    send_n(6, 1'b0);
    finish_frame();

    // Flush coinciding with the accept that completes bank 0
    start_frame();
    send_n(3, 1'b0);
    tick(1'b1, 2'($urandom), 1'b0, 1'b1);
    drain_wait();

    // Out-of-state controls and a stray tb_done are ignored
    tick(1'b0, 2'b00, 1'b0, 1'b1);
    start_frame();
    tick(1'b0, 2'b00, 1'b1, 1'b0);
    force_done = 1'b1;
    tick(1'b1, 2'($urandom), 1'b0, 1'b0);
    force_done = 1'b0;
    send_n(5, 1'b1);
    finish_frame();

    // Reset in the middle of a frame, then a normal frame
    start_frame();
    send_n(3, 1'b0);
    do_reset(2);
    start_frame();
    send_n(5, 1'b1);
    finish_frame();

    // Random frame lengths, valid gaps and traceback delays
    for (int k = 0; k < 8; k++) begin
      tb_delay = int'($urandom_range(1, 6));
      start_frame();
      send_n(int'($urandom_range(0, 11)), 1'b1);
      finish_frame();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
`default_nettype wire
